// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised input, mid-bit sampling, one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err_o pulse output.
module uart_rx #(
  parameter int CLK_FREQ   = 50250000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_val_o,
  input  logic                  data_rdy_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, next_state;

  logic                  rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0]      clk_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  fall, half_hit, bit_hit, cnt_clear;
  logic                  sample_data, stop_sample, frame_good;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad;
`endif

  // Line synchroniser; rx_prev lets IDLE see only a genuine 1->0 edge, so a held break never retriggers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall     = rx_prev & ~rx_s;
  assign half_hit = (clk_cnt == HALF_LAST);
  assign bit_hit  = (clk_cnt == BIT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    cnt_clear   = 1'b0;
    sample_data = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (fall) next_state = START;
      end
      START: begin
        if (half_hit) begin
          cnt_clear  = 1'b1;
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_hit) begin
          cnt_clear   = 1'b1;
          sample_data = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == IDX_LAST) next_state = PARITY;
`else
          if (bit_idx == IDX_LAST) next_state = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_hit) begin
          cnt_clear  = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_hit) begin
          cnt_clear   = 1'b1;
          stop_sample = 1'b1;
          next_state  = IDLE;
        end
      end
      default: begin
        cnt_clear  = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign frame_good = rx_s & ~par_bad;
`else
  assign frame_good = rx_s;
`endif

  // Datapath: bit timing, shift register, holding register and the one-cycle status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      data_val_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
      if (state == PARITY && bit_hit) par_bad <= rx_s ^ (^shreg);
`endif
      clk_cnt <= cnt_clear ? '0 : clk_cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      if (sample_data) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 1'b1;
      end
      if (data_val_o && data_rdy_i) data_val_o <= 1'b0;
      // A word may load into a full holding register only when the old word leaves this same cycle
      if (stop_sample) begin
        frame_err_o <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err_o <= par_bad;
`endif
        if (frame_good) begin
          if (!data_val_o || data_rdy_i) begin
            data_o     <= shreg;
            data_val_o <= 1'b1;
          end else begin
            overrun_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; a frame-level model predicts words and error pulses.
// Define UART_RX_PARITY_EN to exercise the even-parity build.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       data_rdy_i = 1'b1;
  logic [7:0] data_o;
  logic       data_val_o, frame_err_o, overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int         checks = 0;
  int         fails = 0;
  logic [7:0] exp_data[$];
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  int         exp_perr = 0;
  bit         model_full = 1'b0;

  uart_rx #(.CLK_FREQ(16), .BAUD(1), .DATA_WIDTH(8)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rx_i(rx_i),
    .data_o(data_o),
    .data_val_o(data_val_o),
    .data_rdy_i(data_rdy_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pops an expected event of one kind; an event nobody predicted is a failure
  task automatic expectEvent(input string name, inout int pending);
    checks++;
    if (pending > 0) pending--;
    else begin
      fails++;
      $display("[TB] FAIL %s: got unexpected pulse, expected none pending", name);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (data_val_o && data_rdy_i) begin
        if (exp_data.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL word: got unexpected word %0h, expected none", data_o);
        end else begin
          checkOutput("word", {24'h0, data_o}, {24'h0, exp_data.pop_front()});
        end
      end
      if (frame_err_o) expectEvent("frame_err", exp_ferr);
      if (overrun_o) expectEvent("overrun", exp_ovr);
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) expectEvent("parity_err", exp_perr);
`endif
    end
  end

  // Sends one frame; the model predicts its outcome from the frame contents and the holding-register occupancy
  task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_bit,
                               input int rst_bit, input int gap);
    bit par_ok;
    par_ok = (par_bit == ^data);
    if (rst_bit >= 0) model_full = 1'b0;
    else begin
      if (!stop_bit) exp_ferr++;
      if (PARITY_EN && !par_ok) exp_perr++;
      if (stop_bit && (!PARITY_EN || par_ok)) begin
        if (data_rdy_i) exp_data.push_back(data);
        else if (model_full) exp_ovr++;
        else begin
          exp_data.push_back(data);
          model_full = 1'b1;
        end
      end
    end
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      if (i == rst_bit) begin
        tick(CPB / 2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB);
      end
    end
    if (PARITY_EN) begin
      rx_i = par_bit;
      tick(CPB);
    end
    rx_i = stop_bit;
    tick(CPB);
    rx_i = 1'b1;
    tick(gap);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_words_left"}, exp_data.size(), 0);
    checkOutput({name, "_ferr_left"}, exp_ferr, 0);
    checkOutput({name, "_ovr_left"}, exp_ovr, 0);
    checkOutput({name, "_perr_left"}, exp_perr, 0);
  endtask

  initial begin
    logic [7:0] d;
    int         r;
    bit         par;
    tick(3);
    checkOutput("reset_data", {24'h0, data_o}, 0);
    checkOutput("reset_valid", {31'h0, data_val_o}, 0);
    rst_i = 1'b0;
    tick(4);
    checkOutput("idle_valid", {31'h0, data_val_o}, 0);
    checkOutput("idle_ferr", {31'h0, frame_err_o}, 0);
    checkOutput("idle_ovr", {31'h0, overrun_o}, 0);

    d = 8'hA5;
    applyStimulus(d, 1'b1, ^d, -1, 8);
    checkDrained("t1");

    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    tick(24);
    d = 8'hC3;
    applyStimulus(d, 1'b1, ^d, -1, 8);
    checkDrained("t2");

    d = 8'h3C;
    applyStimulus(d, 1'b0, ^d, -1, 16);
    d = 8'h5A;
    applyStimulus(d, 1'b1, ^d, -1, 8);
    checkDrained("t3");

    data_rdy_i = 1'b0;
    d = 8'h11;
    applyStimulus(d, 1'b1, ^d, -1, 4);
    d = 8'h22;
    applyStimulus(d, 1'b1, ^d, -1, 4);
    checkOutput("t4_valid_held", {31'h0, data_val_o}, 1);
    checkOutput("t4_data_held", {24'h0, data_o}, 32'h11);
    checkOutput("t4_ovr_left", exp_ovr, 0);
    data_rdy_i = 1'b1;
    tick();
    data_rdy_i = 1'b0;
    model_full = 1'b0;
    checkOutput("t4_valid_after", {31'h0, data_val_o}, 0);
    checkOutput("t4_data_after", {24'h0, data_o}, 32'h11);
    data_rdy_i = 1'b1;
    checkDrained("t4");

    // Upper nibble all ones keeps the line high after the reset, so no spurious start edge follows
    d = 8'hF5;
    applyStimulus(d, 1'b1, 1'b1, 4, 8);
    checkOutput("t5_valid", {31'h0, data_val_o}, 0);
    d = 8'h81;
    applyStimulus(d, 1'b1, ^d, -1, 8);
    checkDrained("t5");

    if (PARITY_EN) begin
      d = 8'h07;
      applyStimulus(d, 1'b1, 1'b0, -1, 8);
      applyStimulus(d, 1'b1, 1'b1, -1, 8);
      checkDrained("t6");
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rx_i = 1'b0;
        tick($urandom_range(1, 6));
        rx_i = 1'b1;
        tick(20);
      end else begin
        d = 8'($urandom);
        par = (^d) ^ ($urandom_range(0, 7) == 0);
        if (r == 1) applyStimulus(d, 1'b0, par, -1, 16 + $urandom_range(0, 4));
        else        applyStimulus(d, 1'b1, par, -1, $urandom_range(0, 20));
      end
    end
    tick(40);
    checkDrained("random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
